// File: rtl/sccb_slave_if.sv
// SCCB bus lines and register-bank port of the SCCB responder.
// slave = the responder itself; master = the bus master / register bank around it.
interface sccb_slave_if #(
  parameter int ADDR_W = 8
);
  logic              sioc_in;
  logic              siod_in;
  logic              siod_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              busy;

  modport slave (
    input  sioc_in, siod_in, reg_rd_data,
    output siod_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy
  );

  modport master (
    output sioc_in, siod_in, reg_rd_data,
    input  siod_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy
  );
endinterface

// File: rtl/sccb_slave.sv
// SCCB/I2C register-write responder, oversampled on clk with pull-down-only SIOD drive.
// Define SCCB_SLAVE_READ_EN to add read transfers; otherwise read addresses are NACKed.
module sccb_slave #(
  parameter logic [7:0] DEVICE_ADDR = 8'h42,
  parameter int         I2C_ADDR_16 = 0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sccb_slave_if.slave bus
);

  localparam int AW = 8 + 8 * I2C_ADDR_16;

`ifdef SCCB_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
  logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   rw_q, rw_d;
  logic                   addr_byte_q, addr_byte_d;
  logic [AW-1:0]          reg_addr_q, reg_addr_d;
  logic [7:0]             reg_wr_data_q, reg_wr_data_d;
  logic                   reg_wr_en_q, reg_wr_en_d;
  logic                   reg_rd_en_q, reg_rd_en_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   siod_oe_q, siod_oe_d;
  logic                   busy_q, busy_d;

  logic       scl, sda, scl_rise, scl_fall, start_cond, stop_cond;
  logic       rx_state, byte_done;
  logic [7:0] rx_byte;

  assign scl        = sioc_sync_q[SYNC_STAGES-1];
  assign sda        = siod_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl & ~scl_prev_q;
  assign scl_fall   = ~scl & scl_prev_q;
  assign start_cond = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_cond  = scl & scl_prev_q & ~sda_prev_q & sda;
  assign rx_state   = (state_q == DEV_ADDR) || (state_q == REG_ADDR) || (state_q == WR_DATA);
  assign rx_byte    = {shift_q[6:0], sda};
  assign byte_done  = rx_state && scl_rise && (bit_cnt_q == 4'd7);

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    sioc_sync_d   = {sioc_sync_q[SYNC_STAGES-2:0], bus.sioc_in};
    siod_sync_d   = {siod_sync_q[SYNC_STAGES-2:0], bus.siod_in};
    scl_prev_d    = scl;
    sda_prev_d    = sda;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rw_d          = rw_q;
    addr_byte_d   = addr_byte_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    reg_wr_en_d   = 1'b0;
    reg_rd_en_d   = 1'b0;
    rd_pending_d  = reg_rd_en_q;
    siod_oe_d     = siod_oe_q;
    busy_d        = busy_q;

    // Read data is valid the cycle after the request; load it for the next falling edge.
    if (READ_EN && rd_pending_q) shift_d = bus.reg_rd_data;

    if (stop_cond) begin
      state_d   = IDLE;
      siod_oe_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start_cond) begin
      state_d     = DEV_ADDR;
      bit_cnt_d   = '0;
      addr_byte_d = 1'b0;
      busy_d      = 1'b1;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = byte_done ? 4'd0 : bit_cnt_q + 4'd1;
      end

      unique case (state_q)
        IDLE, IGNORE: begin
        end
        DEV_ADDR: if (byte_done) begin
          rw_d    = rx_byte[0];
          state_d = ((rx_byte[7:1] == DEVICE_ADDR[7:1]) && (!rx_byte[0] || READ_EN))
                    ? DEV_ACK : IGNORE;
        end
        REG_ADDR: if (byte_done) begin
          if ((I2C_ADDR_16 != 0) && !addr_byte_q) reg_addr_d[AW-1 -: 8] = rx_byte;
          else                                    reg_addr_d[7:0]       = rx_byte;
          state_d = REG_ACK;
        end
        WR_DATA: if (byte_done) begin
          reg_wr_data_d = rx_byte;
          reg_wr_en_d   = 1'b1;
          state_d       = WR_ACK;
        end
        // ACK states: the first SIOC fall pulls SIOD low, the second releases and moves on.
        DEV_ACK: begin
          if (scl_rise && rw_q) reg_rd_en_d = READ_EN;
          if (scl_fall) begin
            if (!siod_oe_q) siod_oe_d = 1'b1;
            else if (rw_q) begin
              siod_oe_d = ~shift_q[7];
              state_d   = RD_DATA;
            end else begin
              siod_oe_d = 1'b0;
              state_d   = REG_ADDR;
            end
          end
        end
        REG_ACK: if (scl_fall) begin
          if (!siod_oe_q) siod_oe_d = 1'b1;
          else begin
            siod_oe_d = 1'b0;
            if ((I2C_ADDR_16 != 0) && !addr_byte_q) begin
              addr_byte_d = 1'b1;
              state_d     = REG_ADDR;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!siod_oe_q) siod_oe_d = 1'b1;
          else begin
            siod_oe_d  = 1'b0;
            reg_addr_d = reg_addr_q + AW'(1);
            state_d    = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              siod_oe_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = RD_MACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              siod_oe_d = ~shift_q[6];
            end
          end
        end
        // bit_cnt == 1 marks a master ACK whose next byte has already been requested.
        RD_MACK: begin
          if (scl_rise) begin
            if (!sda) begin
              reg_addr_d  = reg_addr_q + AW'(1);
              reg_rd_en_d = READ_EN;
              bit_cnt_d   = 4'd1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
            siod_oe_d = ~shift_q[7];
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sioc_sync_q   <= '1;
      siod_sync_q   <= '1;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rw_q          <= 1'b0;
      addr_byte_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      rd_pending_q  <= 1'b0;
      siod_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sioc_sync_q   <= sioc_sync_d;
      siod_sync_q   <= siod_sync_d;
      scl_prev_q    <= scl_prev_d;
      sda_prev_q    <= sda_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rw_q          <= rw_d;
      addr_byte_q   <= addr_byte_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_en_q   <= reg_rd_en_d;
      rd_pending_q  <= rd_pending_d;
      siod_oe_q     <= siod_oe_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.siod_oe     = siod_oe_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_data = reg_wr_data_q;
  assign bus.reg_wr_en   = reg_wr_en_q;
  assign bus.busy        = busy_q;
`ifdef SCCB_SLAVE_READ_EN
  assign bus.reg_rd_en   = reg_rd_en_q;
`else
  assign bus.reg_rd_en   = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_slave.sv
// Self-checking bench for sccb_slave: an 8-bit-pointer instance (dut0) and a 16-bit one (dut1),
// driven by a bit-banged SCCB master over a wired-AND SIOD line.
module tb_sccb_slave;

  localparam int Q = 5;  // clk cycles per quarter SCCB bit (bit = 20 clk)

  logic clk = 1'b0;
  logic rst_n;
  logic sioc_m, siod_m;
  bit   sel;
  logic siod_line;

  always #5 clk = ~clk;

  sccb_slave_if #(.ADDR_W(8))  if0 ();
  sccb_slave_if #(.ADDR_W(16)) if1 ();

  sccb_slave #(.DEVICE_ADDR(8'h42), .I2C_ADDR_16(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sccb_slave #(.DEVICE_ADDR(8'h42), .I2C_ADDR_16(1), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if0.sioc_in = (sel == 1'b0) ? sioc_m : 1'b1;
  assign if0.siod_in = (sel == 1'b0) ? (siod_m & ~if0.siod_oe) : 1'b1;
  assign if1.sioc_in = (sel == 1'b1) ? sioc_m : 1'b1;
  assign if1.siod_in = (sel == 1'b1) ? (siod_m & ~if1.siod_oe) : 1'b1;
  assign siod_line   = (sel == 1'b0) ? if0.siod_in : if1.siod_in;

  // Register-bank model: data appears the cycle after the read request.
  always @(posedge clk)
    if (if0.reg_rd_en) if0.reg_rd_data <= (if0.reg_addr == 8'h0A) ? 8'h76 : 8'h00;
  assign if1.reg_rd_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected write strobes.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t sb_q[$];

  int   oe_cycles0 = 0;
  int   rd_cnt0    = 0;
  logic [7:0] rd_addr0 = 8'h00;
  logic wr0_prev = 1'b0, wr1_prev = 1'b0;

  task automatic sb_compare(input string who, input logic [15:0] addr, input logic [7:0] data);
    wr_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected_strobe: got addr 0x%0h data 0x%0h expected no strobe",
               who, addr, data);
    end else begin
      e = sb_q.pop_front();
      check({who, "_strobe_addr"}, 32'(addr), 32'(e.addr));
      check({who, "_strobe_data"}, 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (if0.siod_oe) oe_cycles0 = oe_cycles0 + 1;
    if (if0.reg_rd_en) begin
      rd_cnt0  = rd_cnt0 + 1;
      rd_addr0 = if0.reg_addr;
    end
    if (if0.reg_wr_en) begin
      check("dut0_strobe_shape", 32'({wr0_prev, if0.reg_rd_en}), 32'd0);
      sb_compare("dut0", {8'h00, if0.reg_addr}, if0.reg_wr_data);
    end
    if (if1.reg_wr_en) begin
      check("dut1_strobe_shape", 32'({wr1_prev, if1.reg_rd_en}), 32'd0);
      sb_compare("dut1", if1.reg_addr, if1.reg_wr_data);
    end
    wr0_prev = if0.reg_wr_en;
    wr1_prev = if1.reg_wr_en;
  end

  // ---------------- bus master ----------------
  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic drive, output logic line);
    siod_m = drive;
    wait_q(1);
    sioc_m = 1'b1;
    wait_q(1);
    line = siod_line;
    wait_q(1);
    sioc_m = 1'b0;
    wait_q(1);
  endtask

  task automatic start_c();
    siod_m = 1'b1;
    wait_q(1);
    sioc_m = 1'b1;
    wait_q(1);
    siod_m = 1'b0;
    wait_q(1);
    sioc_m = 1'b0;
  endtask

  task automatic stop_c();
    siod_m = 1'b0;
    wait_q(1);
    sioc_m = 1'b1;
    wait_q(1);
    siod_m = 1'b1;
    wait_q(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic line;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], line);
    bit_cycle(1'b1, line);
    ack = ~line;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, line);
      d[i] = line;
    end
    bit_cycle(~mack, line);
    siod_m = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] dev;
    logic [7:0] regb;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_addr_after;
  } vec_t;
  vec_t vecs[6];

  logic       ack;
  logic [7:0] rd;
  int         snap;

  initial begin
    vecs[0] = '{8'h42, 8'h12, 8'h80, 1'b1, 8'h13};
    vecs[1] = '{8'h60, 8'h12, 8'h80, 1'b0, 8'h13};
    vecs[2] = '{8'h42, 8'h00, 8'hFF, 1'b1, 8'h01};
    vecs[3] = '{8'hC2, 8'h55, 8'h11, 1'b0, 8'h01};
    vecs[4] = '{8'h42, 8'h7F, 8'h5A, 1'b1, 8'h80};
    vecs[5] = '{8'h40, 8'h22, 8'h33, 1'b0, 8'h80};

    rst_n  = 1'b0;
    sioc_m = 1'b1;
    siod_m = 1'b1;
    sel    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_siod_oe",     32'(if0.siod_oe),     32'd0);
    check("rst_wr_en",       32'(if0.reg_wr_en),   32'd0);
    check("rst_rd_en",       32'(if0.reg_rd_en),   32'd0);
    check("rst_busy",        32'(if0.busy),        32'd0);
    check("rst_reg_addr",    32'(if0.reg_addr),    32'd0);
    check("rst_wr_data",     32'(if0.reg_wr_data), 32'd0);
    check("rst_dut1_addr",   32'(if1.reg_addr),    32'd0);
    rst_n = 1'b1;
    wait_q(1);

    // Single write transactions, matching and non-matching addresses.
    for (int i = 0; i < 6; i++) begin
      snap = oe_cycles0;
      start_c();
      check($sformatf("v%0d_busy_start", i), 32'(if0.busy), 32'd1);
      send_byte(vecs[i].dev, ack);
      check($sformatf("v%0d_dev_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      send_byte(vecs[i].regb, ack);
      check($sformatf("v%0d_reg_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) sb_q.push_back('{addr: {8'h00, vecs[i].regb}, data: vecs[i].data});
      send_byte(vecs[i].data, ack);
      check($sformatf("v%0d_data_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      stop_c();
      check($sformatf("v%0d_busy_stop", i), 32'(if0.busy), 32'd0);
      check($sformatf("v%0d_oe_seen", i), 32'(oe_cycles0 != snap), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_addr_after", i), 32'(if0.reg_addr), 32'(vecs[i].exp_addr_after));
      check($sformatf("v%0d_sb_empty", i), 32'(sb_q.size()), 32'd0);
    end

    // Burst with pointer wrap-around.
    start_c();
    send_byte(8'h42, ack);
    check("burst_dev_ack", 32'(ack), 32'd1);
    send_byte(8'hFF, ack);
    check("burst_reg_ack", 32'(ack), 32'd1);
    sb_q.push_back('{addr: 16'h00FF, data: 8'hA1});
    sb_q.push_back('{addr: 16'h0000, data: 8'hA2});
    sb_q.push_back('{addr: 16'h0001, data: 8'hA3});
    send_byte(8'hA1, ack);
    check("burst_d0_ack", 32'(ack), 32'd1);
    send_byte(8'hA2, ack);
    check("burst_d1_ack", 32'(ack), 32'd1);
    send_byte(8'hA3, ack);
    check("burst_d2_ack", 32'(ack), 32'd1);
    stop_c();
    check("burst_sb_empty",   32'(sb_q.size()),  32'd0);
    check("burst_addr_after", 32'(if0.reg_addr), 32'h02);

    // Read: set pointer, then read address.
    start_c();
    send_byte(8'h42, ack);
    check("rdptr_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h0A, ack);
    check("rdptr_reg_ack", 32'(ack), 32'd1);
    stop_c();
    snap = rd_cnt0;
    start_c();
    send_byte(8'h43, ack);
`ifdef SCCB_SLAVE_READ_EN
    check("rd_dev_ack", 32'(ack), 32'd1);
    read_byte(1'b0, rd);
    check("rd_data",    32'(rd),               32'h76);
    check("rd_pulses",  32'(rd_cnt0 - snap),   32'd1);
    check("rd_addr",    32'(rd_addr0),         32'h0A);
`else
    check("rd_dev_nack", 32'(ack),             32'd0);
    check("rd_no_pulse", 32'(rd_cnt0 - snap),  32'd0);
`endif
    stop_c();
    check("rd_busy_stop",  32'(if0.busy),     32'd0);
    check("rd_addr_after", 32'(if0.reg_addr), 32'h0A);

    // Repeated START in the middle of a data byte.
    start_c();
    send_byte(8'h42, ack);
    send_byte(8'h20, ack);
    check("rs_reg_ack", 32'(ack), 32'd1);
    bit_cycle(1'b1, ack);
    bit_cycle(1'b0, ack);
    bit_cycle(1'b1, ack);
    bit_cycle(1'b1, ack);
    start_c();
    check("rs_busy", 32'(if0.busy), 32'd1);
    send_byte(8'h42, ack);
    check("rs_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h05, ack);
    sb_q.push_back('{addr: 16'h0005, data: 8'h33});
    send_byte(8'h33, ack);
    check("rs_data_ack", 32'(ack), 32'd1);
    stop_c();
    check("rs_sb_empty",   32'(sb_q.size()),  32'd0);
    check("rs_addr_after", 32'(if0.reg_addr), 32'h06);

    // Reset while SIOD is being pulled for an ACK.
    start_c();
    for (int i = 7; i >= 0; i--) bit_cycle(1'(8'h42 >> i), ack);
    siod_m = 1'b1;
    wait_q(1);
    check("rst_mid_oe_before", 32'(if0.siod_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe_after", 32'(if0.siod_oe), 32'd0);
    check("rst_mid_busy",     32'(if0.busy),    32'd0);
    wait_q(1);
    rst_n = 1'b1;
    sioc_m = 1'b1;
    wait_q(2);
    check("rst_mid_addr", 32'(if0.reg_addr), 32'd0);
    start_c();
    send_byte(8'h42, ack);
    check("post_rst_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h44, ack);
    sb_q.push_back('{addr: 16'h0044, data: 8'h99});
    send_byte(8'h99, ack);
    check("post_rst_data_ack", 32'(ack), 32'd1);
    stop_c();
    check("post_rst_sb_empty", 32'(sb_q.size()), 32'd0);

    // Two-byte register pointer on dut1.
    sel = 1'b1;
    wait_q(1);
    start_c();
    send_byte(8'h42, ack);
    check("a16_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h30, ack);
    check("a16_hi_ack", 32'(ack), 32'd1);
    send_byte(8'h08, ack);
    check("a16_lo_ack", 32'(ack), 32'd1);
    sb_q.push_back('{addr: 16'h3008, data: 8'h55});
    send_byte(8'h55, ack);
    check("a16_data_ack", 32'(ack), 32'd1);
    stop_c();
    check("a16_sb_empty",   32'(sb_q.size()),  32'd0);
    check("a16_addr_after", 32'(if1.reg_addr), 32'h3009);
    check("a16_busy_stop",  32'(if1.busy),     32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
SCCB/I2C responder that receives register writes on an open-drain SIOC/SIOD bus and presents them on a simple register-bank port. It serves as the camera-side counterpart of our SCCB master, either in simulation benches or as a configuration port inside the FPGA. It oversamples the bus with the system clock and uses pull-down-only drive on SIOD (ACK and read data).

Parameters:
DEVICE_ADDR, 8'h42, 8-bit write address; bits [7:1] are matched, bit 0 is R/W.
I2C_ADDR_16, 0, 1 = two register-address bytes (MSB first); 0 = one byte.
SYNC_STAGES, 2, flip-flop stages on each of SIOC and SIOD (minimum 2).

Ports:
clk  input  1  system clock; must be at least 16x the SCCB bit rate.
rst_n  input  1  asynchronous, active-low reset.
sioc_in  input  1  bus SIOC level (asynchronous).
siod_in  input  1  bus SIOD level (asynchronous).
siod_oe  output  1  1 = pull SIOD low; 0 = release.
reg_addr  output  8+8*I2C_ADDR_16  register pointer.
reg_wr_data  output  8  write data.
reg_wr_en  output  1  one-cycle write strobe.
reg_rd_en  output  1  one-cycle read request (used only with the optional feature).
reg_rd_data  input  8  read data; valid on the cycle after reg_rd_en.
busy  output  1  high from START to STOP.

Behaviour:
- Reset (asynchronous): siod_oe=0, reg_wr_en=0, reg_rd_en=0, busy=0, reg_addr=0, reg_wr_data=0, state=IDLE. Reset in the middle of a byte releases SIOD immediately.
- Synchronization and edge detection:
  - SIOC and SIOD each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized copies.
  - START = SIOD falls while SIOC is high. STOP = SIOD rises while SIOC is high.
- Bit timing:
  - Receive bits are sampled on SIOC rising edges, MSB first; a 4-bit bit counter tracks position.
  - siod_oe changes only on SIOC falling edges (one clk after the synchronized fall). The exceptions are STOP and reset, which release it immediately.
- State machine: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR (one or two bytes), REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE.
  - IDLE -> DEV_ADDR on START; busy goes to 1.
  - DEV_ADDR, after 8 bits:
    - If [7:1] matches DEVICE_ADDR[7:1], go to DEV_ACK and drive siod_oe=1 for the 9th clock.
    - Otherwise go to IGNORE with no ACK.
  - Write direction (R/W=0): REG_ADDR bytes are each ACKed, then WR_DATA.
    - Each completed data byte latches reg_wr_data and pulses reg_wr_en for one clk on the 8th SIOC rising edge, with the current reg_addr.
    - The byte is ACKed, then reg_addr increments (wraps at all-ones).
  - Read direction (R/W=1): RD_DATA; see the optional feature.
  - Repeated START in any state: go to DEV_ADDR, clear the bit counter, keep reg_addr.
  - STOP in any state: go to IDLE, siod_oe=0, busy=0. A partial byte is discarded with no strobe.
  - IGNORE: leave only on START or STOP.
- reg_wr_en and reg_rd_en are never asserted in the same cycle. Each strobe is exactly one clk wide.

Optional Feature:
SCCB_SLAVE_READ_EN.
- Defined (reads supported):
  - On the ACK clock of a read-address byte, reg_rd_en pulses at the SIOC rising edge. reg_rd_data is captured into a shift register on the next clk.
  - Starting at the following SIOC falling edge, siod_oe = ~bit, MSB first, for 8 bits. SIOD is released for the 9th (master ACK) bit.
  - Master ACK (SIOD low at the 9th rising edge): reg_addr increments, the next byte is fetched, continue.
  - Master NACK: go to IGNORE and await STOP.
- Undefined: a matching address with R/W=1 is NACKed and the block goes to IGNORE. reg_rd_en is tied to 0.

Test Plan:
1. START, 0x42, 0x12, 0x80, STOP -> SIOD low during all three ACK bits; reg_wr_en pulses once with reg_addr=0x12, reg_wr_data=0x80; busy low after STOP.
2. START, 0x60, 0x12, 0x80, STOP -> siod_oe stays 0 throughout; no reg_wr_en.
3. Burst: 0x42, 0xFF, then data 0xA1, 0xA2, 0xA3 -> three strobes at reg_addr 0xFF, 0x00, 0x01 (wrap-around).
4. READ_EN defined:
   - Bus sequence: write pointer 0x0A, STOP, then START, 0x43.
   - Register model: reg_rd_data=0x76.
   - Expected: one reg_rd_en pulse; SIOD carries 0x76; master NACK then STOP returns to IDLE.
   - With the macro undefined, the same sequence gives no ACK on 0x43.
5. Repeated START mid-data-byte, then 0x42, 0x05, 0x33 -> no strobe for the aborted byte; one strobe with addr 0x05, data 0x33.
6. rst_n asserted while siod_oe=1 during an ACK -> siod_oe=0 within the same cycle; next START is accepted normally.
7. I2C_ADDR_16=1: 0x42, 0x30, 0x08, 0x55 -> four ACKs; strobe with reg_addr=0x3008, data 0x55.
